// File: rtl/mult32_seq.sv
// -----------------------------------------------------------------------------
// mult32_seq -- sequential 32x32 -> 64-bit multiplier (MIPS mult / multu)
//
// Radix-2 shift-add multiplier working on operand magnitudes. A signed request
// is turned into an unsigned multiply of |a| and |b|, and the 64-bit magnitude
// product is negated at the end when the operand signs differ.
//
// One operation takes 34 cycles from the start cycle to the done cycle:
//   IDLE (capture) -> 32 x CALC (one shift-add step each) -> FIX (sign, load).
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous active-high reset
//   start      in   1   begin a multiply (only looked at in IDLE)
//   is_signed  in   1   1 = signed multiply, 0 = unsigned; captured with start
//   a          in  32   multiplicand; captured with start
//   b          in  32   multiplier; captured with start
//   busy       out  1   operation in progress (CALC or FIX)
//   done       out  1   one-cycle pulse, hi/lo carry the new product
//   hi         out 32   product bits [63:32]
//   lo         out 32   product bits [31:0]
// -----------------------------------------------------------------------------
module mult32_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [63:0] acc_q,    acc_d;     // running magnitude product
    logic [63:0] mcand_q,  mcand_d;   // |a|, shifted left one place per step
    logic [31:0] mplier_q, mplier_d;  // |b|, shifted right one place per step
    logic [5:0]  count_q,  count_d;   // completed shift-add steps
    logic        sign_q,   sign_d;    // product must be negated in FIX
    logic [31:0] hi_q,     hi_d;
    logic [31:0] lo_q,     lo_d;
    logic        done_q,   done_d;

    // Magnitude of a 32-bit operand. For 0x80000000 the two's-complement
    // negation wraps back to 0x80000000, which read as unsigned is exactly
    // 2^31, so the most negative operand needs no special case.
    function automatic logic [31:0] magnitude(input logic [31:0] v,
                                              input logic        sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Two's-complement negation of the 64-bit magnitude product.
    function automatic logic [63:0] apply_sign(input logic [63:0] mag,
                                               input logic        neg);
        return neg ? (~mag + 64'd1) : mag;
    endfunction

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (count_q == 6'd31) state_d = FIX;  // 32nd step now
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = (state_q == CALC) || (state_q == FIX);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    // -------------------------------------------------------------------------
    // Datapath next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        sign_d   = sign_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d   = (a[31] ^ b[31]) & is_signed;
                    mcand_d  = {32'd0, magnitude(a, is_signed)};
                    mplier_d = magnitude(b, is_signed);
                    acc_d    = 64'd0;
                    count_d  = 6'd0;
                end
            end
            CALC: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = {mcand_q[62:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                count_d  = count_q + 6'd1;
            end
            FIX: begin
                {hi_d, lo_d} = apply_sign(acc_q, sign_q);
                done_d       = 1'b1;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= 64'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            count_q  <= 6'd0;
            sign_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            sign_q   <= sign_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

endmodule
